// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the Booth multiplier controller
package booth_pkg;

    localparam int BOOTH_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_ADD2 = 3'd3,
        OP_SUB2 = 3'd4
    } booth_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_DONE
    } booth_state_e;

endpackage

// File: rtl/booth_op_decode.sv
// rtl/booth_op_decode.sv - Booth operation decode from register low bits; radix-4 when BOOTH_RADIX4_EN is defined
module booth_op_decode
    import booth_pkg::*;
(
    input  logic [2:0] pp_lsb,
    output booth_op_e  op
);

`ifdef BOOTH_RADIX4_EN
    always_comb begin
        op = OP_NOP;
        case (pp_lsb)
            3'b001, 3'b010: op = OP_ADD;
            3'b011:         op = OP_ADD2;
            3'b100:         op = OP_SUB2;
            3'b101, 3'b110: op = OP_SUB;
            default:        op = OP_NOP;
        endcase
    end
`else
    // Radix-2 only looks at {q0, q-1}; q1 is deliberately ignored.
    logic unused_q1;
    assign unused_q1 = pp_lsb[2];

    always_comb begin
        op = OP_NOP;
        case (pp_lsb[1:0])
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
    end
`endif

endmodule

// File: rtl/booth_ctrl.sv
// rtl/booth_ctrl.sv - Booth multiplier sequencer (ld/en/op, start/done handshakes); radix-4 when BOOTH_RADIX4_EN is defined
module booth_ctrl
    import booth_pkg::*;
#(
    parameter  int WIDTH = BOOTH_WIDTH,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       pp_lsb,
    output logic             ld,
    output logic             en,
    output booth_op_e        op,
    output logic             busy,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             done_valid,
    input  logic             done_ready
);

`ifdef BOOTH_RADIX4_EN
    localparam int N_ITER = WIDTH / 2;
`else
    localparam int N_ITER = WIDTH;
`endif

    booth_state_e state;
    booth_op_e    dec_op;

    booth_op_decode u_decode (
        .pp_lsb (pp_lsb),
        .op     (dec_op)
    );

    // Decode tracks the live register bits; gated so op is NOP outside iterations.
    assign op = en ? dec_op : OP_NOP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            iter_cnt    <= '0;
            start_ready <= 1'b1;
            ld          <= 1'b0;
            en          <= 1'b0;
            busy        <= 1'b0;
            done_valid  <= 1'b0;
        end else begin
            ld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        state       <= ST_LOAD;
                        iter_cnt    <= CNT_W'(N_ITER);
                        ld          <= 1'b1;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state <= ST_ITER;
                    en    <= 1'b1;
                end
                ST_ITER: begin
                    iter_cnt <= iter_cnt - CNT_W'(1);
                    if (iter_cnt == CNT_W'(1)) begin
                        state      <= ST_DONE;
                        en         <= 1'b0;
                        done_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (done_ready) begin
                        state       <= ST_IDLE;
                        done_valid  <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    en          <= 1'b0;
                    done_valid  <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// tb/tb_booth_ctrl.sv - self-checking bench for booth_ctrl with a partial-product model; radix-4 when BOOTH_RADIX4_EN is defined
module tb_booth_ctrl;
    import booth_pkg::*;

    localparam int WIDTH = 16;
    localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef BOOTH_RADIX4_EN
    localparam int N     = WIDTH / 2;
    localparam int SHIFT = 2;
    int exp_dec[8] = '{0, 1, 1, 3, 4, 2, 2, 0};
`else
    localparam int N     = WIDTH;
    localparam int SHIFT = 1;
    int exp_dec[8] = '{0, 1, 2, 0, 0, 1, 2, 0};
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start_valid;
    logic             start_ready;
    logic [2:0]       pp_lsb;
    logic             ld;
    logic             en;
    booth_op_e        op;
    logic             busy;
    logic [CNT_W-1:0] iter_cnt;
    logic             done_valid;
    logic             done_ready;

    logic [2:0]       dec_in;
    booth_op_e        dec_op;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic signed [15:0] cur_m, cur_q;
    logic signed [31:0] exp_prod;
    logic signed [34:0] ppr;
    logic signed [34:0] m_sh;
    logic signed [34:0] addend;
    logic [31:0]        sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pp_lsb      (pp_lsb),
        .ld          (ld),
        .en          (en),
        .op          (op),
        .busy        (busy),
        .iter_cnt    (iter_cnt),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    booth_op_decode u_dec (
        .pp_lsb (dec_in),
        .op     (dec_op)
    );

    // Partial-product register model: {A[17:0], Q[15:0], q-1}; A carries headroom for 2M.
    assign exp_prod = cur_m * cur_q;
    assign m_sh     = {{19{cur_m[15]}}, cur_m} <<< (WIDTH + 1);
    assign pp_lsb   = ppr[2:0];

    always_comb begin
        addend = '0;
        case (op)
            OP_ADD:  addend = m_sh;
            OP_SUB:  addend = -m_sh;
            OP_ADD2: addend = m_sh <<< 1;
            OP_SUB2: addend = -(m_sh <<< 1);
            default: addend = '0;
        endcase
    end

    always @(posedge clk or negedge reset) begin
        if (!reset)  ppr <= '0;
        else if (ld) ppr <= {18'b0, cur_q, 1'b0};
        else if (en) ppr <= (ppr + addend) >>> SHIFT;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on load, pop and compare on completed done handshake; output invariants each cycle.
    always @(negedge clk) begin
        if (ld) sb.push_back(exp_prod);
        if (done_valid && done_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 1);
            else                chk("result", ppr[32:1], sb.pop_front());
        end
        chk("ld_en_excl", 32'(ld & en), 0);
        if (!en) chk("op_nop_when_idle", 32'(op), 32'(OP_NOP));
    end

    task automatic do_req(input logic signed [15:0] mc, input logic signed [15:0] mp, input int hold);
        int k;
        int n_en;
        cur_m = mc;
        cur_q = mp;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        chk("ld_t1", 32'(ld), 1);
        chk("en_t1", 32'(en), 0);
        chk("cnt_t1", 32'(iter_cnt), N);
        k = 1;
        n_en = 0;
        while (!done_valid && k < N + 20) begin
            @(posedge clk); #1;
            k++;
            if (en) n_en++;
        end
        chk("en_cycles", n_en, N);
        chk("done_latency", k, N + 2);
        for (int i = 0; i < hold; i++) begin
            start_valid = (i == 2);
            @(posedge clk); #1;
            chk("bp_done_valid", 32'(done_valid), 1);
            chk("bp_start_ready", 32'(start_ready), 0);
            chk("bp_no_ld", 32'(ld), 0);
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        chk("idle_start_ready", 32'(start_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done_valid", 32'(done_valid), 0);
    endtask

    initial begin
        int k;
        int n;
        int ld_cyc[$];

        reset = 1'b0;
        start_valid = 1'b0;
        done_ready = 1'b0;
        dec_in = '0;
        cur_m = '0;
        cur_q = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", 32'(start_ready), 1);
        chk("rst_ld", 32'(ld), 0);
        chk("rst_en", 32'(en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done_valid", 32'(done_valid), 0);
        chk("rst_op", 32'(op), 32'(OP_NOP));
        chk("rst_iter_cnt", 32'(iter_cnt), 0);
        start_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start_valid = 1'b0;
        chk("rst_sv_busy", 32'(busy), 0);
        chk("rst_sv_ld", 32'(ld), 0);
        chk("rst_sv_cnt", 32'(iter_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            dec_in = 3'(i);
            #1;
            chk("decode_table", 32'(dec_op), exp_dec[i]);
        end

        @(posedge clk); #1;
        do_req(16'sd7, -16'sd3, 0);
        do_req(-16'sd5, 16'sd9, 5);

        // Abort at the 7th iteration with an asynchronous reset.
        cur_m = 16'sd11;
        cur_q = 16'sd13;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        n = 0;
        k = 0;
        while (n < 7 && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (en) n++;
        end
        chk("abort_reach_iter7", n, 7);
        reset = 1'b0;
        #1;
        chk("abort_en", 32'(en), 0);
        chk("abort_ld", 32'(ld), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_start_ready", 32'(start_ready), 1);
        chk("abort_iter_cnt", 32'(iter_cnt), 0);
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        do_req(16'sd123, -16'sd456, 0);

        // Back-to-back with both handshakes tied high.
        cur_m = -16'sd1234;
        cur_q = 16'sd567;
        start_valid = 1'b1;
        done_ready = 1'b1;
        k = 0;
        while (ld_cyc.size() < 3 && k < 3 * (N + 3) + 10) begin
            @(posedge clk); #1;
            k++;
            if (ld) ld_cyc.push_back(cyc);
        end
        start_valid = 1'b0;
        chk("b2b_ld_count", 32'(ld_cyc.size()), 3);
        if (ld_cyc.size() == 3) begin
            chk("b2b_spacing_1", 32'(ld_cyc[1] - ld_cyc[0]), N + 3);
            chk("b2b_spacing_2", 32'(ld_cyc[2] - ld_cyc[1]), N + 3);
        end
        k = 0;
        while (busy && k < N + 20) begin
            @(posedge clk); #1;
            k++;
        end
        done_ready = 1'b0;
        chk("b2b_drained", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_ctrl.md
# booth_ctrl

Sequencing controller for the Booth multiplier's 33-bit partial-product register. It accepts a multiply request through a valid/ready handshake and pulses `ld` for one cycle to load the `{A, Q, q-1}` register. It then asserts `en` for exactly one iteration per step, decoding the Booth operation from the register's low bits each cycle. When the iterations are complete it presents a done handshake. It sits beside `partial_product` and the add/shift datapath, and it is the only block that drives their `ld`, `en` and operation select.

## Interface
- `WIDTH`, default 16: operand width; iteration count in radix-2 mode; must be even.
- `CNT_W`, default `$clog2(WIDTH)+1`: iteration counter width (localparam).

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  multiply request.
- `start_ready`  out  1  controller idle; request accepted when both are high.
- `pp_lsb`  in  3  partial-product register bits `[2:0]` = `{q1, q0, q-1}`.
- `ld`  out  1  load strobe to the partial-product register.
- `en`  out  1  iteration enable to the partial-product register.
- `op`  out  3  `booth_op_e`: NOP, ADD, SUB, ADD2, SUB2.
- `busy`  out  1  high in LOAD, ITER and DONE.
- `iter_cnt`  out  CNT_W  iterations remaining.
- `done_valid`  out  1  result in the register is final.
- `done_ready`  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE → LOAD → ITER → DONE → IDLE.
- IDLE
  - `start_ready`=1.
  - On `start_valid`: go to LOAD and set `iter_cnt`=N, where N = WIDTH, or WIDTH/2 in radix-4 mode.
- LOAD
  - `ld`=1 for one cycle, `en`=0, `op`=NOP.
  - Next state is ITER unconditionally.
- ITER
  - `en`=1.
  - `op` is decoded combinationally from the current `pp_lsb`.
  - `iter_cnt` decrements each cycle.
  - When `iter_cnt`==1, the next state is DONE.
- DONE
  - `done_valid`=1, `en`=0, `op`=NOP.
  - Hold until `done_ready`, then go to IDLE.
- Radix-2 decode on `pp_lsb[1:0]`: 01→ADD, 10→SUB, 00 and 11→NOP.
- Output rules:
  - `ld` and `en` are never high together.
  - `op` is NOP whenever `en`=0.
- Requests:
  - `start_valid` outside IDLE is ignored; `start_ready`=0.
  - A request is never queued.

## Timing
- Reset values:
  - state IDLE, `iter_cnt`=0.
  - `start_ready`=1.
  - `ld`=`en`=`busy`=`done_valid`=0, `op`=NOP.
- Request accepted at edge t:
  - `ld` is high in cycle t+1.
  - `en` is high in cycles t+2 … t+1+N.
  - `done_valid` rises at t+2+N.
- If `done_ready` is already high when `done_valid` rises, DONE lasts one cycle.
  - IDLE follows, and the next request is accepted no earlier than one cycle after DONE.
  - Back-to-back request spacing is N+3 cycles.
- Reset asserted mid-operation:
  - Immediately go to IDLE and drop `ld`, `en` and `done_valid`.
  - The datapath register is reset by its own reset.
- `done_ready` outside DONE has no effect.

## Configuration
- `BOOTH_RADIX4_EN` defined:
  - N = WIDTH/2 iterations.
  - `op` is decoded from `pp_lsb[2:0]`: 000/111→NOP, 001/010→ADD, 011→ADD2, 100→SUB2, 101/110→SUB.
- Not defined:
  - N = WIDTH.
  - Only `pp_lsb[1:0]` is used; ADD2 and SUB2 are never produced.

## Structure
- `booth_pkg` holds:
  - `booth_op_e`, 3-bit, with NOP=0, ADD=1, SUB=2, ADD2=3, SUB2=4.
  - `booth_state_e`.
  - The default-width constant.
- Sub-module `booth_op_decode`: combinational `pp_lsb` → `op`, with the radix selected by `BOOTH_RADIX4_EN`.

## Test plan
- Reset held low:
  - Required: `start_ready`=1, `ld`=`en`=`busy`=`done_valid`=0, `op`=NOP.
  - Then pulse `start_valid` during reset: no state change.
- Radix-2 multiply of 7 × −3 with a `partial_product` plus adder model:
  - `ld` in cycle t+1, 16 `en` cycles, `done_valid` at t+18.
  - Register `[32:1]` = −21 sign-extended.
- Backpressure: `done_ready` low for 5 cycles.
  - `done_valid` holds, `start_ready`=0, and a `start_valid` pulse is ignored.
  - Raising `done_ready` returns the FSM to IDLE.
- Reset pulsed low at ITER cycle 7:
  - `en`=0 immediately, state IDLE, `iter_cnt`=0.
  - A new request then completes normally.
- Back-to-back: `start_valid` and `done_ready` tied high.
  - `ld` pulses are exactly 19 cycles apart.
- `BOOTH_RADIX4_EN` build:
  - `pp_lsb`=3'b011 gives `op`=ADD2; 3'b100 gives SUB2.
  - Exactly 8 `en` cycles; 7 × −3 yields −21.
